if_window_loader: RTL and testbench
===================================

// Module: if_window_loader
// PURPOSE
// - Moves input-feature words from the IF buffer into the circular IF scratchpad; publishes the live
//   window [win_start..win_end] to the PE datapath and frees space as windows are consumed.
// - Successor to the single-row IF reader: full-depth use (count-based full), queued end-of-row
//   pointers (several rows in flight), and a sliding-window mode with a fixed stride.
// PARAMETERS
// - ADDR_LEN       4   scratchpad address width
// - SCRATCH_DEPTH  16  scratchpad entries, any value 2..2**ADDR_LEN (need not be a power of 2)
// - SCRATCH_WIDTH  8   word width; scratch data path is external, carried for consistency only
// - MODE           0   0 = row mode (window = one end-flag-delimited row); 1 = slide mode
// - END_Q          2   row mode: pending end-pointer queue depth, 1..4
// - WIN_LEN        4   slide mode: window length in entries, 1..SCRATCH_DEPTH
// - STRIDE         1   slide mode: entries retired per win_done, 1..WIN_LEN
// PORTS
// - clk            in   1           clock, all state on rising edge
// - rst_n          in   1           asynchronous reset, active low
// - start          in   1           begin new feature map; clears pointers, queue and occupancy
// - buf_empty      in   1           IF buffer has no word
// - buf_end_flag   in   1           word at IF buffer head is last of its row
// - win_done       in   1           consumer finished current window (1-cycle pulse)
// - buf_read       out  1           pop IF buffer this cycle
// - scratch_wen    out  1           write scratchpad this cycle (always equal to buf_read)
// - scratch_waddr  out  ADDR_LEN    scratchpad write address
// - win_start      out  ADDR_LEN    first entry of live window
// - win_end        out  ADDR_LEN    last entry of live window
// - win_valid      out  1           window bounds valid
// - occupancy      out  ADDR_LEN+1  entries written and not retired
// - scratch_full   out  1           occupancy == SCRATCH_DEPTH
// BEHAVIOUR
// - Reset (rst_n=0, async): every output and register 0; state IDLE.
// - FSM: IDLE -start-> CLEAR (1 cycle, sync-clears waddr/start/end/queue/occupancy) -> RUN.
//   start in any state forces CLEAR next cycle; win_done during CLEAR is ignored.
// - Write rule (RUN): buf_read = scratch_wen = ~buf_empty & ~scratch_full & ~q_block, where
//   q_block = MODE0 & buf_end_flag & queue full. Combinational, same-cycle pop.
// - scratch_waddr increments per write and wraps SCRATCH_DEPTH-1 -> 0.
// - occupancy_next = occupancy + wen - retired; write and retire in same cycle both apply.
// - All pointer sums are taken modulo SCRATCH_DEPTH, computed at ADDR_LEN+1 bits, no truncation wrap.
// - Row mode: write with buf_end_flag pushes scratch_waddr into end queue. win_valid = queue
//   non-empty; win_end = queue head; win_start = start register. On win_done & win_valid:
//   retired = win_end - win_start + 1 (mod depth, 1..DEPTH), start <= win_end+1, queue pops;
//   next row's bounds visible next cycle with no gap if already queued.
// - Slide mode: end flags ignored; win_valid = occupancy >= WIN_LEN; win_end = win_start+WIN_LEN-1.
//   On win_done & win_valid: retired = STRIDE, win_start += STRIDE.
// - win_done with win_valid=0: ignored, no state change.
// - Full scratch: writes stall until a retire; stall releases in the cycle after the retire.
// - A row longer than SCRATCH_DEPTH is a fatal usage error (deadlock); checked by assertion only.
// STRUCTURE
// - Package if_loader_pkg: FSM state encoding (IDLE, CLEAR, RUN), MODE_ROW/MODE_SLIDE constants.
// - Sub-module if_end_ptr_fifo: END_Q x ADDR_LEN pointer FIFO with push/pop/clear, empty/full,
//   head output; push and pop in the same cycle are both honoured.
// - Top: FSM, write counter, start register, occupancy counter, mode muxing.
// TESTING
// - Reset mid-RUN with occupancy 5 -> all outputs 0 asynchronously; start then loads from addr 0.
// - MODE0, DEPTH16: row of 6 words (end on 6th) -> win 0..5 valid after the 6th write;
//   win_done -> start=6, occupancy drops by 6.
// - MODE0, END_Q=2: three 3-word rows, no win_done -> 2 rows queued, 3rd row's end word stalls;
//   win_done -> end word written the next cycle, window 3..5 with no invalid gap.
// - Wrap/full, DEPTH=12 (non-pow2): 12 writes -> scratch_full=1, waddr wraps 11->0, buf_read=0;
//   win_done on a 12-word row in the same cycle as a pending word -> start=0, occupancy 0.
// - MODE1, WIN_LEN=4, STRIDE=2: after 4 writes win 0..3; win_done + simultaneous write ->
//   win 2..5, occupancy 3.
// - start pulse during RUN with 2 queued rows -> CLEAR cycle, win_valid=0, all pointers 0.

Source files
------------

// File: rtl/if_loader_pkg.sv
`default_nettype none
// =====================================================================
// if_loader_pkg : shared state encoding and mode constants for the loader
// Rev 1.0
// =====================================================================
package if_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_RUN   = 2'd2
  } loader_state_e;

  localparam int MODE_ROW   = 0;
  localparam int MODE_SLIDE = 1;

endpackage
`default_nettype wire

// File: rtl/if_end_ptr_fifo.sv
`default_nettype none
// =====================================================================
// if_end_ptr_fifo : small queue of end-of-row scratchpad pointers
// Rev 1.0
// =====================================================================
module if_end_ptr_fifo
  import if_loader_pkg::*;
#(
  parameter int ADDR_LEN = 4,
  parameter int END_Q    = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clear,
  input  logic                push,
  input  logic                pop,
  input  logic [ADDR_LEN-1:0] push_ptr,
  output logic [ADDR_LEN-1:0] head,
  output logic                empty,
  output logic                full
);

  // Storage is sized for the largest legal queue; only END_Q slots are used.
  localparam int         SLOTS = 4;
  localparam logic [1:0] LAST  = 2'(END_Q - 1);
  localparam logic [2:0] CAP   = 3'(END_Q);

  logic [ADDR_LEN-1:0] mem_q [SLOTS];
  logic [ADDR_LEN-1:0] mem_d [SLOTS];
  logic [1:0]          wr_q, wr_d, rd_q, rd_d;
  logic [2:0]          count_q, count_d;
  logic                do_push, do_pop;

  function automatic logic [1:0] bump(input logic [1:0] p);
    return (p == LAST) ? 2'd0 : p + 2'd1;
  endfunction

  always_comb begin
    mem_d   = mem_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    do_pop  = pop & (count_q != 3'd0);
    do_push = push & ((count_q != CAP) | do_pop);
    if (do_push) begin
      mem_d[wr_q] = push_ptr;
      wr_d        = bump(wr_q);
    end
    if (do_pop) begin
      rd_d = bump(rd_q);
    end
    count_d = count_q + 3'(do_push) - 3'(do_pop);
    if (clear) begin
      wr_d    = 2'd0;
      rd_d    = 2'd0;
      count_d = 3'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SLOTS; i++) begin
        mem_q[i] <= '0;
      end
      wr_q    <= 2'd0;
      rd_q    <= 2'd0;
      count_q <= 3'd0;
    end else begin
      mem_q   <= mem_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end

  assign head  = mem_q[rd_q];
  assign empty = (count_q == 3'd0);
  assign full  = (count_q == CAP);

endmodule
`default_nettype wire

// File: rtl/if_window_loader.sv
`default_nettype none
// =====================================================================
// if_window_loader : fills the circular IF scratchpad, publishes the live window
// Rev 1.0
// =====================================================================
module if_window_loader
  import if_loader_pkg::*;
#(
  parameter int ADDR_LEN      = 4,
  parameter int SCRATCH_DEPTH = 16,
  parameter int SCRATCH_WIDTH = 8,
  parameter int MODE          = 0,
  parameter int END_Q         = 2,
  parameter int WIN_LEN       = 4,
  parameter int STRIDE        = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                buf_empty,
  input  logic                buf_end_flag,
  input  logic                win_done,
  output logic                buf_read,
  output logic                scratch_wen,
  output logic [ADDR_LEN-1:0] scratch_waddr,
  output logic [ADDR_LEN-1:0] win_start,
  output logic [ADDR_LEN-1:0] win_end,
  output logic                win_valid,
  output logic [ADDR_LEN:0]   occupancy,
  output logic                scratch_full
);

  localparam bit                  IS_ROW    = (MODE == MODE_ROW);
  localparam bit                  IS_SLIDE  = (MODE == MODE_SLIDE);
  localparam logic [ADDR_LEN:0]   DEPTH     = (ADDR_LEN+1)'(SCRATCH_DEPTH);
  localparam logic [ADDR_LEN-1:0] LAST_ADDR = ADDR_LEN'(SCRATCH_DEPTH - 1);
  localparam logic [ADDR_LEN:0]   WIN_SPAN  = (ADDR_LEN+1)'(WIN_LEN - 1);
  localparam logic [ADDR_LEN:0]   WIN_LEN_W = (ADDR_LEN+1)'(WIN_LEN);
  localparam logic [ADDR_LEN:0]   STRIDE_W  = (ADDR_LEN+1)'(STRIDE);
  localparam logic [ADDR_LEN:0]   ONE       = (ADDR_LEN+1)'(1);

  loader_state_e       state_q, state_d;
  logic [ADDR_LEN-1:0] waddr_q, waddr_d;
  logic [ADDR_LEN-1:0] wstart_q, wstart_d;
  logic [ADDR_LEN:0]   occ_q, occ_d;
  logic [ADDR_LEN:0]   retired;
  logic [ADDR_LEN-1:0] q_head, end_ptr;
  logic                run, clearing, full, q_block, wen, valid, fire;
  logic                q_push, q_pop, q_empty, q_full;

  // Modular add; operands stay below 2*DEPTH so one correction suffices.
  function automatic logic [ADDR_LEN-1:0] add_mod(input logic [ADDR_LEN-1:0] a,
                                                  input logic [ADDR_LEN:0]   b);
    logic [ADDR_LEN:0] s;
    s = {1'b0, a} + b;
    if (s >= DEPTH) s = s - DEPTH;
    return s[ADDR_LEN-1:0];
  endfunction

  // Inclusive length of [s..e] around the ring, 1..DEPTH.
  function automatic logic [ADDR_LEN:0] span(input logic [ADDR_LEN-1:0] s,
                                             input logic [ADDR_LEN-1:0] e);
    if (e >= s) return {1'b0, e - s} + ONE;
    else        return DEPTH - {1'b0, s - e} + ONE;
  endfunction

  generate
    if (IS_ROW) begin : g_row_queue
      if_end_ptr_fifo #(
        .ADDR_LEN (ADDR_LEN),
        .END_Q    (END_Q)
      ) u_end_q (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (clearing),
        .push     (q_push),
        .pop      (q_pop),
        .push_ptr (waddr_q),
        .head     (q_head),
        .empty    (q_empty),
        .full     (q_full)
      );
    end else begin : g_no_queue
      logic unused_q_ctl;
      assign unused_q_ctl = ^{q_push, q_pop, buf_end_flag, IS_SLIDE};
      assign q_head  = '0;
      assign q_empty = 1'b1;
      assign q_full  = 1'b0;
    end
  endgenerate

  assign run      = (state_q == ST_RUN);
  assign clearing = start | (state_q == ST_CLEAR);
  assign full     = (occ_q == DEPTH);
  // An end word needs a queue slot; hold it at the buffer head until one frees.
  assign q_block  = IS_ROW & buf_end_flag & q_full;
  assign wen      = run & ~buf_empty & ~full & ~q_block;
  assign valid    = run & (IS_ROW ? ~q_empty : (occ_q >= WIN_LEN_W));
  assign fire     = win_done & valid;
  assign q_push   = IS_ROW & wen & buf_end_flag;
  assign q_pop    = IS_ROW & fire;
  assign end_ptr  = IS_ROW ? (q_empty ? '0 : q_head) : add_mod(wstart_q, WIN_SPAN);
  assign retired  = fire ? (IS_ROW ? span(wstart_q, q_head) : STRIDE_W) : '0;

  always_comb begin
    state_d  = state_q;
    waddr_d  = waddr_q;
    wstart_d = wstart_q;
    occ_d    = occ_q;
    if (start) begin
      state_d = ST_CLEAR;
    end else begin
      case (state_q)
        ST_IDLE:  state_d = ST_IDLE;
        ST_CLEAR: state_d = ST_RUN;
        ST_RUN:   state_d = ST_RUN;
        default:  state_d = ST_IDLE;
      endcase
    end
    if (clearing) begin
      waddr_d  = '0;
      wstart_d = '0;
      occ_d    = '0;
    end else begin
      if (wen) begin
        waddr_d = (waddr_q == LAST_ADDR) ? '0 : waddr_q + ADDR_LEN'(1);
      end
      if (fire) begin
        wstart_d = IS_ROW ? add_mod(q_head, ONE) : add_mod(wstart_q, STRIDE_W);
      end
      occ_d = occ_q + (ADDR_LEN+1)'(wen) - retired;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      waddr_q  <= '0;
      wstart_q <= '0;
      occ_q    <= '0;
    end else begin
      state_q  <= state_d;
      waddr_q  <= waddr_d;
      wstart_q <= wstart_d;
      occ_q    <= occ_d;
    end
  end

  // A full scratchpad with no complete row queued means a row exceeds the depth.
  always @(posedge clk) begin
    if (rst_n && run && IS_ROW) begin
      assert (!(full && q_empty));
    end
  end

  assign buf_read      = wen;
  assign scratch_wen   = wen;
  assign scratch_waddr = waddr_q;
  assign win_start     = wstart_q;
  assign win_end       = run ? end_ptr : '0;
  assign win_valid     = valid;
  assign occupancy     = occ_q;
  assign scratch_full  = full;

endmodule
`default_nettype wire

// File: tb/tb_if_window_loader.sv
`default_nettype none
// =====================================================================
// tb_if_window_loader : directed checks on row, wrap/full and slide configurations
// Rev 1.0
// =====================================================================
module tb_if_window_loader;

  localparam int AW = 4;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  // a: row mode depth 16, b: row mode depth 12, c: slide mode win 4 stride 2
  logic a_start, a_empty, a_end, a_done, a_rd, a_wen, a_wv, a_full;
  logic [AW-1:0] a_waddr, a_ws, a_we;
  logic [AW:0]   a_occ;
  logic b_start, b_empty, b_end, b_done, b_rd, b_wen, b_wv, b_full;
  logic [AW-1:0] b_waddr, b_ws, b_we;
  logic [AW:0]   b_occ;
  logic c_start, c_empty, c_end, c_done, c_rd, c_wen, c_wv, c_full;
  logic [AW-1:0] c_waddr, c_ws, c_we;
  logic [AW:0]   c_occ;

  if_window_loader #(.ADDR_LEN(AW), .SCRATCH_DEPTH(16), .SCRATCH_WIDTH(8), .MODE(0),
                     .END_Q(2), .WIN_LEN(4), .STRIDE(1)) u_a (
    .clk(clk), .rst_n(rst_n), .start(a_start), .buf_empty(a_empty), .buf_end_flag(a_end),
    .win_done(a_done), .buf_read(a_rd), .scratch_wen(a_wen), .scratch_waddr(a_waddr),
    .win_start(a_ws), .win_end(a_we), .win_valid(a_wv), .occupancy(a_occ),
    .scratch_full(a_full));

  if_window_loader #(.ADDR_LEN(AW), .SCRATCH_DEPTH(12), .SCRATCH_WIDTH(8), .MODE(0),
                     .END_Q(2), .WIN_LEN(4), .STRIDE(1)) u_b (
    .clk(clk), .rst_n(rst_n), .start(b_start), .buf_empty(b_empty), .buf_end_flag(b_end),
    .win_done(b_done), .buf_read(b_rd), .scratch_wen(b_wen), .scratch_waddr(b_waddr),
    .win_start(b_ws), .win_end(b_we), .win_valid(b_wv), .occupancy(b_occ),
    .scratch_full(b_full));

  if_window_loader #(.ADDR_LEN(AW), .SCRATCH_DEPTH(16), .SCRATCH_WIDTH(8), .MODE(1),
                     .END_Q(2), .WIN_LEN(4), .STRIDE(2)) u_c (
    .clk(clk), .rst_n(rst_n), .start(c_start), .buf_empty(c_empty), .buf_end_flag(c_end),
    .win_done(c_done), .buf_read(c_rd), .scratch_wen(c_wen), .scratch_waddr(c_waddr),
    .win_start(c_ws), .win_end(c_we), .win_valid(c_wv), .occupancy(c_occ),
    .scratch_full(c_full));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    {a_start, a_end, a_done} = '0; a_empty = 1'b1;
    {b_start, b_end, b_done} = '0; b_empty = 1'b1;
    {c_start, c_end, c_done} = '0; c_empty = 1'b1;
    #2;
    chk("rst_a_rd",    32'(a_rd), 0);
    chk("rst_a_waddr", 32'(a_waddr), 0);
    chk("rst_a_wv",    32'(a_wv), 0);
    chk("rst_a_occ",   32'(a_occ), 0);
    chk("rst_a_we",    32'(a_we), 0);
    chk("rst_c_we",    32'(c_we), 0);
    tick(); tick();
    rst_n = 1'b1;

    // fill 5 words, then reset asynchronously mid-run
    a_start = 1'b1; tick(); a_start = 1'b0; tick();
    a_empty = 1'b0; #1;
    chk("run_a_rd", 32'(a_rd), 1);
    chk("run_a_waddr0", 32'(a_waddr), 0);
    repeat (5) tick();
    a_empty = 1'b1; #1;
    chk("mid_a_occ5", 32'(a_occ), 5);
    a_empty = 1'b0;
    rst_n = 1'b0; #1;
    chk("arst_a_occ",   32'(a_occ), 0);
    chk("arst_a_waddr", 32'(a_waddr), 0);
    chk("arst_a_rd",    32'(a_rd), 0);
    chk("arst_a_wen",   32'(a_wen), 0);
    rst_n = 1'b1; a_empty = 1'b1;

    // one 6-word row
    a_start = 1'b1; tick(); a_start = 1'b0; tick();
    a_empty = 1'b0; #1;
    chk("row_a_waddr0", 32'(a_waddr), 0);
    repeat (5) tick();
    a_end = 1'b1; #1;
    chk("row_a_waddr5", 32'(a_waddr), 5);
    tick();
    a_empty = 1'b1; a_end = 1'b0; #1;
    chk("row_a_wv",  32'(a_wv), 1);
    chk("row_a_ws",  32'(a_ws), 0);
    chk("row_a_we",  32'(a_we), 5);
    chk("row_a_occ", 32'(a_occ), 6);
    a_done = 1'b1; tick(); a_done = 1'b0; #1;
    chk("ret_a_ws",  32'(a_ws), 6);
    chk("ret_a_occ", 32'(a_occ), 0);
    chk("ret_a_wv",  32'(a_wv), 0);

    // three 3-word rows: third end word stalls on a full queue
    a_empty = 1'b0;
    for (int i = 0; i < 8; i++) begin
      a_end = (i % 3 == 2);
      tick();
    end
    a_end = 1'b1; #1;
    chk("q_a_rd_stall", 32'(a_rd), 0);
    chk("q_a_wv",       32'(a_wv), 1);
    chk("q_a_ws",       32'(a_ws), 6);
    chk("q_a_we",       32'(a_we), 8);
    chk("q_a_occ",      32'(a_occ), 8);
    chk("q_a_waddr",    32'(a_waddr), 14);
    a_done = 1'b1; #1;
    chk("q_a_rd_done_cyc", 32'(a_rd), 0);
    tick(); a_done = 1'b0; #1;
    chk("q_a_rd_release", 32'(a_rd), 1);
    chk("q_a_wv_nogap",   32'(a_wv), 1);
    chk("q_a_ws2",        32'(a_ws), 9);
    chk("q_a_we2",        32'(a_we), 11);
    chk("q_a_occ2",       32'(a_occ), 5);
    tick();
    a_empty = 1'b1; a_end = 1'b0; #1;
    chk("q_a_occ3",   32'(a_occ), 6);
    chk("q_a_waddr3", 32'(a_waddr), 15);
    chk("q_a_we3",    32'(a_we), 11);

    // start with two rows queued
    a_start = 1'b1; tick(); a_start = 1'b0; a_empty = 1'b0; #1;
    chk("clr_a_wv",    32'(a_wv), 0);
    chk("clr_a_ws",    32'(a_ws), 0);
    chk("clr_a_we",    32'(a_we), 0);
    chk("clr_a_waddr", 32'(a_waddr), 0);
    chk("clr_a_occ",   32'(a_occ), 0);
    chk("clr_a_rd",    32'(a_rd), 0);
    tick(); #1;
    chk("clr_a_rd_run", 32'(a_rd), 1);
    chk("clr_a_wv_run", 32'(a_wv), 0);
    a_empty = 1'b1;

    // depth 12: one 12-word row fills and wraps
    b_start = 1'b1; tick(); b_start = 1'b0; tick();
    b_empty = 1'b0;
    repeat (11) tick();
    b_end = 1'b1; tick(); b_end = 1'b0; #1;
    chk("wrap_b_waddr", 32'(b_waddr), 0);
    chk("wrap_b_full",  32'(b_full), 1);
    chk("wrap_b_occ",   32'(b_occ), 12);
    chk("wrap_b_rd",    32'(b_rd), 0);
    chk("wrap_b_wen",   32'(b_wen), 0);
    chk("wrap_b_wv",    32'(b_wv), 1);
    chk("wrap_b_ws",    32'(b_ws), 0);
    chk("wrap_b_we",    32'(b_we), 11);
    b_done = 1'b1; tick(); b_done = 1'b0; #1;
    chk("wret_b_ws",   32'(b_ws), 0);
    chk("wret_b_occ",  32'(b_occ), 0);
    chk("wret_b_full", 32'(b_full), 0);
    chk("wret_b_rd",   32'(b_rd), 1);
    chk("wret_b_wv",   32'(b_wv), 0);
    tick(); b_empty = 1'b1; #1;
    chk("wpost_b_occ",   32'(b_occ), 1);
    chk("wpost_b_waddr", 32'(b_waddr), 1);

    // slide mode, window 4, stride 2
    c_start = 1'b1; tick(); c_start = 1'b0; tick();
    c_empty = 1'b0;
    repeat (3) tick(); #1;
    chk("sl_c_wv3",  32'(c_wv), 0);
    chk("sl_c_occ3", 32'(c_occ), 3);
    tick(); #1;
    chk("sl_c_wv",  32'(c_wv), 1);
    chk("sl_c_ws",  32'(c_ws), 0);
    chk("sl_c_we",  32'(c_we), 3);
    chk("sl_c_occ", 32'(c_occ), 4);
    c_done = 1'b1; tick(); c_done = 1'b0; c_empty = 1'b1; #1;
    chk("sl2_c_ws",  32'(c_ws), 2);
    chk("sl2_c_we",  32'(c_we), 5);
    chk("sl2_c_occ", 32'(c_occ), 3);
    chk("sl2_c_wv",  32'(c_wv), 0);
    c_done = 1'b1; tick(); c_done = 1'b0; #1;
    chk("ign_c_ws",  32'(c_ws), 2);
    chk("ign_c_occ", 32'(c_occ), 3);
    c_empty = 1'b0; tick(); c_empty = 1'b1; #1;
    chk("sl3_c_wv",    32'(c_wv), 1);
    chk("sl3_c_occ",   32'(c_occ), 4);
    chk("sl3_c_waddr", 32'(c_waddr), 6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
